// File: rtl/hazard_unit_if.sv
// rtl/hazard_unit_if.sv - pipeline-to-hazard-unit signal bundle.
// master = pipeline datapath side, slave = hazard_unit side.
interface hazard_unit_if;
  logic [31:0] InstrD;
  logic [4:0]  Rs1E;
  logic [4:0]  Rs2E;
  logic [4:0]  RdE;
  logic [1:0]  ResultSrcE;
  logic        PCSrcE;
  logic [4:0]  RdM;
  logic        RegWriteM;
  logic [4:0]  RdW;
  logic        RegWriteW;
  logic [1:0]  ForwardAE;
  logic [1:0]  ForwardBE;
  logic        StallF;
  logic        StallD;
  logic        FlushD;
  logic        FlushE;
  logic [1:0]  perf_sel;
  logic        perf_clr;
  logic [31:0] perf_data;

  modport master (
    output InstrD, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
    output RdM, RegWriteM, RdW, RegWriteW, perf_sel, perf_clr,
    input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, perf_data
  );

  modport slave (
    input  InstrD, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
    input  RdM, RegWriteM, RdW, RegWriteW, perf_sel, perf_clr,
    output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, perf_data
  );
endinterface

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - forwarding, load-use stall and branch flush control.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_unit (
  input  logic        clk,
  input  logic        reset,
  hazard_unit_if.slave hz
);

  typedef enum logic {ST_BOOT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  w_rs1d;
  logic [4:0]  w_rs2d;
  logic        w_lw_stall;
  logic        w_run;
  logic [1:0]  w_fwd_a;
  logic [1:0]  w_fwd_b;
  logic [31:0] w_perf_data;
  logic        w_unused;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       wr_m, input logic [4:0] rd_m,
                                         input logic       wr_w, input logic [4:0] rd_w);
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
      return 2'b10;
    else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign w_rs1d     = hz.InstrD[19:15];
  assign w_rs2d     = hz.InstrD[24:20];
  assign w_lw_stall = (hz.ResultSrcE == 2'b01) && (hz.RdE != 5'd0) &&
                      ((hz.RdE == w_rs1d) || (hz.RdE == w_rs2d));
  assign w_fwd_a    = fwd_sel(hz.Rs1E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
  assign w_fwd_b    = fwd_sel(hz.Rs2E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
  // Reset is folded in combinationally so a reset mid-stall releases the stall at once.
  assign w_run      = (r_state == ST_RUN) && !reset;

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= ST_BOOT;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    hz.ForwardAE = 2'b00;
    hz.ForwardBE = 2'b00;
    hz.StallF    = 1'b0;
    hz.StallD    = 1'b0;
    hz.FlushD    = 1'b1;
    hz.FlushE    = 1'b1;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_BOOT;
    endcase
    if (w_run) begin
      hz.ForwardAE = w_fwd_a;
      hz.ForwardBE = w_fwd_b;
      hz.StallF    = w_lw_stall;
      hz.StallD    = w_lw_stall;
      hz.FlushD    = hz.PCSrcE;
      hz.FlushE    = w_lw_stall | hz.PCSrcE;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_cycles;
  logic [31:0] r_stalls;
  logic [31:0] r_flushes;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset || hz.perf_clr) begin
      r_cycles  <= '0;
      r_stalls  <= '0;
      r_flushes <= '0;
    end else if (r_state == ST_RUN) begin
      r_cycles <= sat_inc(r_cycles);
      if (w_lw_stall)
        r_stalls <= sat_inc(r_stalls);
      if (hz.PCSrcE)
        r_flushes <= sat_inc(r_flushes);
    end
  end

  always_comb begin
    w_perf_data = '0;
    if (!reset) begin
      case (hz.perf_sel)
        2'b00:   w_perf_data = r_cycles;
        2'b01:   w_perf_data = r_stalls;
        2'b10:   w_perf_data = r_flushes;
        default: w_perf_data = '0;
      endcase
    end
  end

  assign w_unused = ^{hz.InstrD[31:25], hz.InstrD[14:0]};
`else
  assign w_perf_data = '0;
  assign w_unused    = ^{hz.InstrD[31:25], hz.InstrD[14:0], hz.perf_sel, hz.perf_clr};
`endif

  assign hz.perf_data = w_perf_data;

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed self-checking bench for hazard_unit.
// Counter values are checked only when HAZARD_PERF_CNT_EN is defined; otherwise perf_data must read 0.
module tb_hazard_unit;

  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;

  hazard_unit_if hz ();

  hazard_unit dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stim();
    hz.InstrD     = 32'h0;
    hz.Rs1E       = 5'd0;
    hz.Rs2E       = 5'd0;
    hz.RdE        = 5'd0;
    hz.ResultSrcE = 2'b00;
    hz.PCSrcE     = 1'b0;
    hz.RdM        = 5'd0;
    hz.RegWriteM  = 1'b0;
    hz.RdW        = 5'd0;
    hz.RegWriteW  = 1'b0;
  endtask

  task automatic load_use_stim();
    hz.ResultSrcE = 2'b01;
    hz.RdE        = 5'd7;
    hz.InstrD     = 32'h0070_0000;
  endtask

  task automatic check_ctrl(input string tag, input logic sf, input logic sd,
                            input logic fd, input logic fe);
    chk({tag, "_StallF"}, {31'd0, hz.StallF}, {31'd0, sf});
    chk({tag, "_StallD"}, {31'd0, hz.StallD}, {31'd0, sd});
    chk({tag, "_FlushD"}, {31'd0, hz.FlushD}, {31'd0, fd});
    chk({tag, "_FlushE"}, {31'd0, hz.FlushE}, {31'd0, fe});
  endtask

  task automatic check_perf(input string tag, input logic [1:0] sel, input logic [31:0] exp);
    hz.perf_sel = sel;
    #1;
`ifdef HAZARD_PERF_CNT_EN
    chk(tag, hz.perf_data, exp);
`else
    chk(tag, hz.perf_data, (exp & 32'h0));
`endif
  endtask

  initial begin
    n_assert     = 0;
    n_fail       = 0;
    reset        = 1'b1;
    hz.perf_sel  = 2'b00;
    hz.perf_clr  = 1'b0;
    clear_stim();
    load_use_stim();
    hz.PCSrcE    = 1'b1;
    hz.RegWriteM = 1'b1;
    hz.RdM       = 5'd5;
    hz.Rs1E      = 5'd5;
    #1;
    // Reset: outputs fixed regardless of hazard stimulus
    check_ctrl("rst", 1'b0, 1'b0, 1'b1, 1'b1);
    chk("rst_ForwardAE", {30'd0, hz.ForwardAE}, 32'd0);
    check_perf("rst_perf", 2'b00, 32'd0);

    tick(); tick(); tick();
    reset = 1'b0;
    #1;
    check_ctrl("boot", 1'b0, 1'b0, 1'b1, 1'b1);
    chk("boot_ForwardAE", {30'd0, hz.ForwardAE}, 32'd0);
    check_perf("boot_perf", 2'b00, 32'd0);
    clear_stim();

    tick();
    #1;
    check_ctrl("run0", 1'b0, 1'b0, 1'b0, 1'b0);
    check_perf("run0_cycles", 2'b00, 32'd0);
    tick();
    check_perf("run1_cycles", 2'b00, 32'd1);

    load_use_stim();
    #1;
    check_ctrl("lw", 1'b1, 1'b1, 1'b0, 1'b1);
    check_perf("lw_stalls_pre", 2'b01, 32'd0);
    tick();
    check_perf("lw_stalls_post", 2'b01, 32'd1);

    hz.PCSrcE = 1'b1;
    #1;
    check_ctrl("br_lw", 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    clear_stim();
    #1;
    check_perf("br_flushes", 2'b10, 32'd1);
    check_perf("br_stalls", 2'b01, 32'd2);
    check_perf("br_cycles", 2'b00, 32'd3);
    check_perf("sel11_zero", 2'b11, 32'd0);

    hz.PCSrcE = 1'b1;
    #1;
    check_ctrl("br_only", 1'b0, 1'b0, 1'b1, 1'b1);
    hz.PCSrcE = 1'b0;

    hz.RegWriteM = 1'b1; hz.RdM = 5'd5;
    hz.RegWriteW = 1'b1; hz.RdW = 5'd5;
    hz.Rs1E = 5'd5;
    #1;
    chk("fwdA_M_prio", {30'd0, hz.ForwardAE}, 32'd2);
    hz.RegWriteM = 1'b0;
    #1;
    chk("fwdA_W", {30'd0, hz.ForwardAE}, 32'd1);
    hz.RegWriteW = 1'b0;
    #1;
    chk("fwdA_none", {30'd0, hz.ForwardAE}, 32'd0);

    hz.RegWriteM = 1'b1; hz.RdM = 5'd0; hz.Rs2E = 5'd0;
    hz.RegWriteW = 1'b1; hz.RdW = 5'd0;
    #1;
    chk("fwdB_x0", {30'd0, hz.ForwardBE}, 32'd0);
    hz.Rs2E = 5'd9; hz.RdW = 5'd9; hz.RdM = 5'd3; hz.Rs1E = 5'd4;
    #1;
    chk("fwdB_W", {30'd0, hz.ForwardBE}, 32'd1);
    chk("fwdA_nomatch", {30'd0, hz.ForwardAE}, 32'd0);
    hz.RdM = 5'd9;
    #1;
    chk("fwdB_M", {30'd0, hz.ForwardBE}, 32'd2);
    clear_stim();

    hz.ResultSrcE = 2'b01; hz.RdE = 5'd12; hz.InstrD = 32'h0006_0000;
    #1;
    check_ctrl("lw_rs1", 1'b1, 1'b1, 1'b0, 1'b1);
    hz.RdE = 5'd0; hz.InstrD = 32'h0000_0000;
    #1;
    check_ctrl("lw_x0", 1'b0, 1'b0, 1'b0, 1'b0);
    hz.ResultSrcE = 2'b10; hz.RdE = 5'd12; hz.InstrD = 32'h0006_0000;
    #1;
    check_ctrl("nonload", 1'b0, 1'b0, 1'b0, 1'b0);
    clear_stim();

`ifdef HAZARD_PERF_CNT_EN
    dut.r_stalls = 32'hFFFF_FFFE;
    load_use_stim();
    tick(); tick(); tick();
    check_perf("sat_stalls", 2'b01, 32'hFFFF_FFFF);
    clear_stim();
    hz.perf_clr = 1'b1;
    tick();
    hz.perf_clr = 1'b0;
    check_perf("clr_stalls", 2'b01, 32'd0);
    check_perf("clr_cycles", 2'b00, 32'd0);
`endif

    load_use_stim();
    hz.RegWriteM = 1'b1; hz.RdM = 5'd5; hz.Rs1E = 5'd5;
    hz.perf_sel = 2'b00;
    tick();
    check_ctrl("pre_rst", 1'b1, 1'b1, 1'b0, 1'b1);
    reset = 1'b1;
    #1;
    check_ctrl("mid_rst", 1'b0, 1'b0, 1'b1, 1'b1);
    chk("mid_rst_ForwardAE", {30'd0, hz.ForwardAE}, 32'd0);
    check_perf("mid_rst_perf", 2'b00, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check_ctrl("boot2", 1'b0, 1'b0, 1'b1, 1'b1);
    check_perf("boot2_perf", 2'b00, 32'd0);
    tick();
    check_ctrl("run2", 1'b1, 1'b1, 1'b0, 1'b1);
    chk("run2_ForwardAE", {30'd0, hz.ForwardAE}, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 InstrD  input  32  decode-stage instruction; Rs1D=InstrD[19:15], Rs2D=InstrD[24:20].
REQ-004 Rs1E, Rs2E, RdE  input  5 each  execute-stage register addresses.
REQ-005 ResultSrcE  input  2  execute-stage result select; 2'b01 = load.
REQ-006 PCSrcE  input  1  taken branch/jump resolved in execute.
REQ-007 RdM  input  5; RegWriteM  input  1  memory-stage destination and write enable.
REQ-008 RdW  input  5; RegWriteW  input  1  writeback-stage destination and write enable.
REQ-009 ForwardAE, ForwardBE  output  2 each  operand forward select: 00 register file, 01 ResultW, 10 ALUResultM.
REQ-010 StallF, StallD  output  1 each  hold PC register / decode register.
REQ-011 FlushD, FlushE  output  1 each  clear decode / execute register.
REQ-012 perf_sel  input  2; perf_clr  input  1; perf_data  output  32  performance-counter access.

Function
REQ-013 ForwardAE SHALL be 10 when RegWriteM, RdM!=0 and RdM==Rs1E; else 01 when RegWriteW, RdW!=0 and RdW==Rs1E; else 00. M has priority over W.
REQ-014 ForwardBE SHALL follow REQ-013 with Rs2E in place of Rs1E.
REQ-015 lwStall SHALL be 1 when ResultSrcE==01, RdE!=0 and RdE equals Rs1D or Rs2D.
REQ-016 In state RUN: StallF=StallD=lwStall; FlushD=PCSrcE; FlushE=lwStall|PCSrcE. All combinational, same cycle.
REQ-017 If lwStall and PCSrcE are both 1, StallF=StallD=1, FlushD=1 and FlushE=1.
REQ-018 FSM states: BOOT and RUN. Reset enters BOOT. BOOT lasts exactly one cycle after reset deasserts, then moves to RUN unconditionally. RUN stays in RUN until reset.
REQ-019 In BOOT and while reset=1: FlushD=FlushE=1, StallF=StallD=0, ForwardAE=ForwardBE=00. These outputs do not depend on any other input.
REQ-020 Register x0 (address 0) SHALL never trigger a forward or a stall.

Reset
REQ-021 On a clock edge with reset=1: state<=BOOT and all counters<=0. Reset applied mid-stall drops StallF/StallD to 0 in that same cycle.
REQ-022 perf_data SHALL read 0 during reset and in the cycle after it.

Configuration
REQ-023 Macro HAZARD_PERF_CNT_EN. When defined, the block contains three 32-bit counters:
  - cycles: increments every RUN cycle.
  - stalls: increments each RUN cycle with lwStall=1.
  - flushes: increments each RUN cycle with PCSrcE=1.
REQ-024 perf_sel selects perf_data: 00 cycles, 01 stalls, 10 flushes, 11 zero. The read is combinational from the counter registers.
REQ-025 Counters saturate at 0xFFFFFFFF and do not wrap. perf_clr=1 zeroes all counters at the next edge and takes priority over increment.
REQ-026 When HAZARD_PERF_CNT_EN is undefined: no counters are built, perf_data is tied to 0, perf_sel and perf_clr are ignored, and all other behaviour is unchanged.

Verification
REQ-027 Forward priority: RegWriteM=1, RdM=5, RegWriteW=1, RdW=5, Rs1E=5 -> ForwardAE=10. With RegWriteM=0 -> ForwardAE=01.
REQ-028 x0 guard: RegWriteM=1, RdM=0, Rs2E=0 -> ForwardBE=00.
REQ-029 Load-use: ResultSrcE=01, RdE=7, InstrD[24:20]=7 -> StallF=StallD=FlushE=1, FlushD=0, and the stalls counter increments by 1.
REQ-030 Branch with load: PCSrcE=1 together with REQ-029 stimulus -> StallF=StallD=FlushD=FlushE=1, and the flushes counter increments.
REQ-031 Boot: hold reset 3 cycles, then release -> FlushD=FlushE=1 through the release cycle plus one BOOT cycle; RUN starts after that, with cycles=1 one edge later.
REQ-032 Saturation (macro defined): preload stalls to 0xFFFFFFFE, apply 3 load-use cycles -> reads 0xFFFFFFFF. Then perf_clr=1 -> reads 0 on the next cycle.
